// File: rtl/transmitter_link_training_pkg.sv
// Shared symbol constants, state encoding and defaults for the
// transmit-side link-training sequencer.
package transmitter_link_training_pkg;

    // 8b/10b symbols used by the training sequence
    localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle
    localparam logic [7:0] K28_1 = 8'h3C;  // alignment-complete marker
    localparam logic [7:0] D10_2 = 8'h4A;  // alternating edge-search pattern

    localparam int TRAIN_LEN_DEF = 1024;
    localparam int ALIGN_LEN_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRAIN,
        ST_ALIGN,
        ST_MARK,
        ST_DATA
    } train_state_e;

    // One symbol as presented to the physical IOB
    typedef struct packed {
        logic       k;
        logic [7:0] data;
    } sym_t;

    function automatic sym_t mk_sym(input logic k, input logic [7:0] data);
        sym_t s;
        s.k    = k;
        s.data = data;
        return s;
    endfunction

endpackage

// File: rtl/transmitter_link_training_if.sv
// User byte handshake plus the packet bus toward the transmitter IOB.
interface transmitter_link_training_if;

    logic       i_tx_valid;
    logic       i_tx_k_en;
    logic [7:0] i_tx_byte;
    logic       o_tx_ready;
    logic       o_packet_k_en;
    logic [7:0] o_packet_byte;

    // Link layer / IOB side
    modport master (
        output i_tx_valid, i_tx_k_en, i_tx_byte,
        input  o_tx_ready, o_packet_k_en, o_packet_byte
    );

    // Sequencer side
    modport slave (
        input  i_tx_valid, i_tx_k_en, i_tx_byte,
        output o_tx_ready, o_packet_k_en, o_packet_byte
    );

endinterface

// File: rtl/transmitter_link_training.sv
// Transmit link-training sequencer: D10.2 edge search, K28.5 comma run,
// one-cycle K28.1 marker, then user-byte passthrough with K28.5 idles.
module transmitter_link_training
    import transmitter_link_training_pkg::*;
#(
    parameter int TRAIN_LEN = TRAIN_LEN_DEF,
    parameter int ALIGN_LEN = ALIGN_LEN_DEF
) (
    input  logic i_clk_120,
    input  logic i_clk_120_rst_n,
    input  logic i_train_start,
    input  logic i_train_hold,
    output logic o_train_busy,
    output logic o_train_done,
    transmitter_link_training_if.slave tx
);

    localparam int MAX_LEN = (TRAIN_LEN > ALIGN_LEN) ? TRAIN_LEN : ALIGN_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_LEN - 1);
    localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(MAX_LEN);

    train_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    sym_t             pkt_q, pkt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;

    // A pending start takes priority over a user byte in the same cycle.
    assign tx.o_tx_ready = (state_q == ST_DATA) & ~i_train_start;
    assign accept        = tx.o_tx_ready & tx.i_tx_valid;
    assign cnt_inc       = (cnt_q >= CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    // State, shared counter and registered outputs
    always_ff @(posedge i_clk_120) begin
        if (!i_clk_120_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pkt_q   <= mk_sym(1'b1, K28_5);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pkt_q   <= pkt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state and the symbol/flags that go with it; outputs are keyed
    // on the next state so they line up with the registered state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pkt_d   = mk_sym(1'b1, K28_5);

        case (state_q)
            ST_IDLE: ;
            ST_TRAIN: begin
                cnt_d = cnt_inc;
                if ((cnt_q >= TRAIN_LAST) && !i_train_hold) begin
                    state_d = ST_ALIGN;
                    cnt_d   = '0;
                end
            end
            ST_ALIGN: begin
                cnt_d = cnt_inc;
                if (cnt_q >= ALIGN_LAST) begin
                    state_d = ST_MARK;
                    cnt_d   = '0;
                end
            end
            ST_MARK: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: ;
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Restart from any state, abandoning any marker in flight
        if (i_train_start) begin
            state_d = ST_TRAIN;
            cnt_d   = '0;
        end

        case (state_d)
            ST_TRAIN: pkt_d = mk_sym(1'b0, D10_2);
            ST_ALIGN: pkt_d = mk_sym(1'b1, K28_5);
            ST_MARK:  pkt_d = mk_sym(1'b1, K28_1);
            ST_DATA:  pkt_d = accept ? mk_sym(tx.i_tx_k_en, tx.i_tx_byte)
                                     : mk_sym(1'b1, K28_5);
            default:  pkt_d = mk_sym(1'b1, K28_5);
        endcase

        busy_d = (state_d == ST_TRAIN) || (state_d == ST_ALIGN) || (state_d == ST_MARK);
        done_d = (state_d == ST_DATA);
    end

    assign tx.o_packet_k_en = pkt_q.k;
    assign tx.o_packet_byte = pkt_q.data;
    assign o_train_busy     = busy_q;
    assign o_train_done     = done_q;

endmodule
